seq_arith_unit: RTL

Registered, handshaked arithmetic unit. It executes ADD, SUB, INC, DEC and a multi-cycle MUL on DATA_WIDTH operands, and produces status flags. It sits between the instruction-decode stage and the writeback stage of the datapath and replaces the purely combinational arithmetic unit. A valid/ready handshake on each side lets a multi-cycle multiply stall upstream without losing results.

---
 rtl/arith_pkg.sv | 24 ++
 rtl/seq_arith_unit_if.sv | 29 ++
 rtl/seq_arith_unit_shift_add_mult.sv | 47 ++++
 rtl/seq_arith_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared opcodes, FSM state encoding and status-flag bundle for seq_arith_unit.
package arith_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
    logic err;
  } flags_t;

endpackage

// File: rtl/seq_arith_unit_if.sv
// Operand/result handshake bundle for seq_arith_unit (master = upstream/downstream driver, slave = unit).
interface seq_arith_unit_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [2:0]            arith_op;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] result_hi;
  logic                  carry_out;
  logic                  zero;
  logic                  negative;
  logic                  overflow;
  logic                  err;

  modport master (
    output in_valid, a, b, arith_op, out_ready,
    input  in_ready, out_valid, result, result_hi, carry_out, zero, negative, overflow, err
  );

  modport slave (
    input  in_valid, a, b, arith_op, out_ready,
    output in_ready, out_valid, result, result_hi, carry_out, zero, negative, overflow, err
  );
endinterface

// File: rtl/seq_arith_unit_shift_add_mult.sv
// Sequential shift-add multiplier: one partial-product step per cycle over DATA_WIDTH cycles.
module shift_add_mult #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [2*DATA_WIDTH-1:0] product_o
);
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  logic [2*DATA_WIDTH-1:0] mcand_q;
  logic [DATA_WIDTH-1:0]   mplier_q;
  logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]           count_q;

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (start_i) begin
      mcand_q  <= {{DATA_WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      count_q  <= CW'(DATA_WIDTH);
    end else if (busy_o) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_d;
      count_q  <= count_q - CW'(1);
    end
  end

  // The final step's sum is exposed combinationally so the product lands in the same edge.
  assign busy_o    = (count_q != '0);
  assign done_o    = (count_q == CW'(1));
  assign product_o = acc_d;

endmodule

// File: rtl/seq_arith_unit.sv
// Registered, handshaked ADD/SUB/INC/DEC unit with optional sequential MUL (define SEQ_ARITH_MUL_EN).
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_arith_unit_if.slave   bus
);
  localparam int unsigned W = DATA_WIDTH;

  state_e        state_q, state_d;
  logic [W-1:0]  result_q, result_d;
  flags_t        flags_q, flags_d;
  logic          accept;
  logic          take_mul;

  logic [W-1:0]  alu_res;
  flags_t        alu_flags;
  logic [W-1:0]  opnd_b;
  logic [W:0]    wide;
  logic          is_sub;
  logic          legal;

  assign bus.in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    opnd_b    = bus.b;
    is_sub    = 1'b0;
    legal     = 1'b1;
    alu_res   = '0;
    alu_flags = '0;
    case (bus.arith_op)
      OP_ADD:  ;
      OP_SUB:  is_sub = 1'b1;
      OP_INC:  opnd_b = W'(1);
      OP_DEC: begin
        opnd_b = W'(1);
        is_sub = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    wide = is_sub ? ({1'b0, bus.a} - {1'b0, opnd_b}) : ({1'b0, bus.a} + {1'b0, opnd_b});
    if (legal) begin
      alu_res            = wide[W-1:0];
      alu_flags.carry    = wide[W];
      alu_flags.zero     = (wide[W-1:0] == '0);
      alu_flags.negative = wide[W-1];
      alu_flags.overflow = is_sub
        ? ((bus.a[W-1] != opnd_b[W-1]) && (wide[W-1] != bus.a[W-1]))
        : ((bus.a[W-1] == opnd_b[W-1]) && (wide[W-1] != bus.a[W-1]));
    end else begin
      alu_flags.err = 1'b1;
    end
  end

`ifdef SEQ_ARITH_MUL_EN
  logic             mul_busy, mul_done;
  logic [2*W-1:0]   mul_prod;
  logic [W-1:0]     result_hi_q, result_hi_d;

  assign take_mul = accept && (bus.arith_op == OP_MUL);

  shift_add_mult #(.DATA_WIDTH(W)) u_mult (
    .clk       (clk),
    .rst       (rst),
    .start_i   (take_mul),
    .a_i       (bus.a),
    .b_i       (bus.b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) result_hi_q <= '0;
    else     result_hi_q <= result_hi_d;
  end

  assign bus.result_hi = result_hi_q;
`else
  assign take_mul      = 1'b0;
  assign bus.result_hi = '0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef SEQ_ARITH_MUL_EN
    result_hi_d = result_hi_q;
`endif
    case (state_q)
      ST_IDLE: ;
`ifdef SEQ_ARITH_MUL_EN
      ST_MUL_BUSY: begin
        if (mul_done) begin
          result_d         = mul_prod[W-1:0];
          result_hi_d      = mul_prod[2*W-1:W];
          flags_d          = '0;
          flags_d.zero     = (mul_prod == '0);
          flags_d.negative = mul_prod[2*W-1];
          state_d          = ST_DONE;
        end else if (!mul_busy) begin
          state_d = ST_IDLE;
        end
      end
`endif
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Result registers keep their previous contents while a multiply is in flight.
    if (take_mul) begin
      state_d = ST_MUL_BUSY;
    end else if (accept) begin
      result_d = alu_res;
      flags_d  = alu_flags;
      state_d  = ST_DONE;
`ifdef SEQ_ARITH_MUL_EN
      result_hi_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = flags_q.carry;
  assign bus.zero      = flags_q.zero;
  assign bus.negative  = flags_q.negative;
  assign bus.overflow  = flags_q.overflow;
  assign bus.err       = flags_q.err;

endmodule
